qed_replay_cache: RTL and testbench

- Sits directly upstream of the QED instruction-modification stage, between fetch and the QED modify stage.
- In record mode it forwards each fetched original instruction and stores a copy in a circular buffer.
- In replay mode it re-issues the stored originals in program order on qic_qimux_instruction, so the modify stage can rewrite them into register- and memory-partitioned duplicates.
- It tracks how many originals are still outstanding and flags when originals and duplicates are balanced.

---
 rtl/qed_replay_cache.sv | 109 ++++++++++
 tb/tb_qed_replay_cache.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/qed_replay_cache.sv
// Replay cache upstream of the QED modify stage: records original instructions
// into a circular buffer and re-issues them in program order for duplication.
module qed_replay_cache #(
    parameter int                  DEPTH     = 16,
    parameter int                  ADDR_W    = 4,
    parameter int                  INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               exec_dup,
    input  logic               stall,
    input  logic [INSTR_W-1:0] ifu_qed_instruction,
    input  logic               ifu_valid,
    output logic               ifu_ready,
    output logic [INSTR_W-1:0] qic_qimux_instruction,
    output logic               qic_valid,
    output logic [ADDR_W:0]    occupancy,
    output logic               full,
    output logic               empty,
    output logic               qed_ready
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic               out_valid_q, out_valid_d;
    logic               written_q, written_d;
    logic               qed_ready_q, qed_ready_d;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign ifu_ready = !stall && (!ena || (!exec_dup && !full));

    assign qic_qimux_instruction = out_instr_q;
    assign qic_valid             = out_valid_q;
    assign qed_ready             = qed_ready_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_instr_d = out_instr_q;
        out_valid_d = out_valid_q;
        written_d   = written_q;
        qed_ready_d = qed_ready_q;
        mem_we      = 1'b0;

        if (!stall) begin
            out_instr_d = NOP_INSTR;
            out_valid_d = 1'b0;
            if (!ena) begin
                if (ifu_valid) begin
                    out_instr_d = ifu_qed_instruction;
                    out_valid_d = 1'b1;
                end
            end else if (!exec_dup) begin
                if (ifu_valid && !full) begin
                    out_instr_d = ifu_qed_instruction;
                    out_valid_d = 1'b1;
                    // NOP fillers pass through but are never worth duplicating.
                    if (ifu_qed_instruction != NOP_INSTR) begin
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_ONE;
                        written_d = 1'b1;
                    end
                end
            end else if (!empty) begin
                out_instr_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
            end
            qed_ready_d = (wr_ptr_d == rd_ptr_d) && !exec_dup && written_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_instr_q <= NOP_INSTR;
            out_valid_q <= 1'b0;
            written_q   <= 1'b0;
            qed_ready_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
            written_q   <= written_d;
            qed_ready_q <= qed_ready_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= ifu_qed_instruction;
        end
    end

endmodule

// File: tb/tb_qed_replay_cache.sv
// Scoreboard bench for qed_replay_cache: a queue-based reference model predicts
// each edge's output, and an independent monitor pops and compares it.
module tb_qed_replay_cache;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, ena, exec_dup, stall, ifu_valid;
    logic [31:0] ifu_qed_instruction;
    logic        ifu_ready, qic_valid, full, empty, qed_ready;
    logic [31:0] qic_qimux_instruction;
    logic [4:0]  occupancy;

    always #5 clk = ~clk;

    qed_replay_cache dut (
        .clk                   (clk),
        .rst                   (rst),
        .ena                   (ena),
        .exec_dup              (exec_dup),
        .stall                 (stall),
        .ifu_qed_instruction   (ifu_qed_instruction),
        .ifu_valid             (ifu_valid),
        .ifu_ready             (ifu_ready),
        .qic_qimux_instruction (qic_qimux_instruction),
        .qic_valid             (qic_valid),
        .occupancy             (occupancy),
        .full                  (full),
        .empty                 (empty),
        .qed_ready             (qed_ready)
    );

    typedef struct {
        logic        v;
        logic [31:0] i;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_fifo[$];
    bit          written_m = 1'b0;
    bit          qrdy_m    = 1'b0;
    bit          inited    = 1'b0;
    int          checks    = 0;
    int          failures  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] x;
        do x = $urandom; while (x == NOP);
        return x;
    endfunction

    // One clock cycle: drive inputs, predict, advance, check state outputs.
    task automatic cyc(input bit r, input bit e, input bit d, input bit s,
                       input bit v, input logic [31:0] ins);
        exp_t ex;
        rst = r; ena = e; exec_dup = d; stall = s;
        ifu_valid = v; ifu_qed_instruction = ins;
        #1;
        if (inited)
            check("ifu_ready", ifu_ready,
                  !s && (!e || (!d && model_fifo.size() < DEPTH)));
        ex.v = 1'b0; ex.i = NOP;
        if (r) begin
            model_fifo.delete();
            written_m = 1'b0;
            qrdy_m    = 1'b0;
            inited    = 1'b1;
            exp_q.push_back(ex);
        end else if (!s) begin
            if (!e) begin
                if (v) begin ex.v = 1'b1; ex.i = ins; end
            end else if (!d) begin
                if (v && model_fifo.size() < DEPTH) begin
                    ex.v = 1'b1; ex.i = ins;
                    if (ins != NOP) begin
                        model_fifo.push_back(ins);
                        written_m = 1'b1;
                    end
                end
            end else if (model_fifo.size() > 0) begin
                ex.v = 1'b1;
                ex.i = model_fifo.pop_front();
            end
            qrdy_m = (model_fifo.size() == 0) && !d && written_m;
            exp_q.push_back(ex);
        end
        @(posedge clk);
        @(negedge clk);
        check("occupancy", occupancy, model_fifo.size());
        check("full", full, model_fifo.size() == DEPTH);
        check("empty", empty, model_fifo.size() == 0);
        check("qed_ready", qed_ready, qrdy_m);
    endtask

    // Monitor: every non-stalled edge presents a new output to compare.
    bit          edge_seen = 1'b0;
    bit          edge_stall, edge_rst;
    logic        prev_v;
    logic [31:0] prev_i;

    always @(posedge clk) begin
        edge_seen  <= 1'b1;
        edge_stall <= stall;
        edge_rst   <= rst;
    end

    always @(negedge clk) begin
        if (edge_seen) begin
            if (edge_stall && !edge_rst) begin
                check("hold_valid", qic_valid, prev_v);
                check("hold_instr", qic_qimux_instruction, prev_i);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow actual=valid:%0b instr:%0h required=no output",
                         qic_valid, qic_qimux_instruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("qic_valid", qic_valid, e.v);
                check("qic_instr", qic_qimux_instruction, e.i);
            end
            prev_v = qic_valid;
            prev_i = qic_qimux_instruction;
        end
    end

    initial begin
        bit d_r;
        // Reset, record A/B/C, replay them, return to record.
        cyc(1, 1, 0, 0, 0, NOP);
        cyc(1, 1, 0, 0, 0, NOP);
        cyc(0, 1, 0, 0, 1, 32'h00500093);
        cyc(0, 1, 0, 0, 1, 32'h00108133);
        cyc(0, 1, 0, 0, 1, 32'h0020A023);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 1, rnd_instr());
        cyc(0, 1, 0, 0, 0, NOP);
        cyc(0, 1, 0, 0, 0, NOP);

        // Fill to full, attempt a 17th, replay with a 2-cycle stall mid-way.
        for (int i = 0; i < 17; i++) cyc(0, 1, 0, 0, 1, rnd_instr());
        for (int i = 0; i < 18; i++) cyc(0, 1, 1, (i == 5 || i == 6), 0, NOP);

        // Wrap: three more across the pointer wrap.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, rnd_instr());
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, NOP);

        // NOP filter and pass-through with frozen occupancy.
        cyc(0, 1, 0, 0, 1, rnd_instr());
        cyc(0, 1, 0, 0, 1, NOP);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, rnd_instr());
        cyc(0, 0, 1, 0, 0, rnd_instr());
        cyc(0, 0, 0, 1, 1, rnd_instr());

        // Reset mid-replay with five outstanding.
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 1, rnd_instr());
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, NOP);
        cyc(1, 1, 1, 0, 0, NOP);
        cyc(0, 1, 1, 0, 0, NOP);

        // Randomized traffic.
        d_r = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            if ($urandom_range(0, 11) == 0) d_r = !d_r;
            ins = ($urandom_range(0, 7) == 0) ? NOP : rnd_instr();
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) != 0,
                d_r,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) != 0,
                ins);
        end

        cyc(0, 1, 0, 0, 0, NOP);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
